// File: rtl/pmem_pkg.sv
// rtl/pmem_pkg.sv - shared widths and types for the cache physical-memory port
package pmem_pkg;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int BEATS   = LINE_W / BURST_W;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } adaptor_state_t;

    typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - converts one-line cache requests into 4-beat 64-bit memory bursts
module cacheline_adaptor
    import pmem_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    input  logic [31:0]  address_i,
    input  logic         read_i,
    input  logic         write_i,
    output logic         resp_o,
    input  logic [63:0]  burst_i,
    output logic [63:0]  burst_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    input  logic         resp_i
);

    adaptor_state_t state;
    logic [1:0]     cnt;
    line_t          line_reg;
    logic           last_beat;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^address_i[4:0];
    assign last_beat        = (cnt == 2'(BEATS - 1));

    // line_reg holds the writeback line, or accumulates a fill so line_o only
    // changes once the whole line has arrived
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            line_reg  <= '0;
            line_o    <= '0;
            address_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_i) begin
                        line_reg  <= line_i;
                        address_o <= {address_i[31:5], 5'b0};
                        cnt       <= 2'd0;
                        state     <= WR_BURST;
                    end else if (read_i) begin
                        address_o <= {address_i[31:5], 5'b0};
                        cnt       <= 2'd0;
                        state     <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        line_reg[BURST_W*cnt +: BURST_W] <= burst_i;
                        cnt <= cnt + 2'd1;
                        if (last_beat) begin
                            line_o <= {burst_i, line_reg[LINE_W-BURST_W-1:0]};
                            state  <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        cnt <= cnt + 2'd1;
                        if (last_beat) begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign read_o  = (state == RD_BURST);
    assign write_o = (state == WR_BURST);
    assign resp_o  = (state == DONE);
    assign burst_o = line_reg[BURST_W*cnt +: BURST_W];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - self-checking bench for cacheline_adaptor
module tb_cacheline_adaptor;
    import pmem_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int tests = 0;
    int fails = 0;

    // model: the last completed fill and last latched line address
    line_t       last_fill = '0;
    logic [31:0] last_addr = '0;

    cacheline_adaptor dut (
        .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i),
        .resp_o(resp_o), .burst_i(burst_i), .burst_o(burst_o),
        .address_o(address_o), .read_o(read_o), .write_o(write_o),
        .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    // Starts at a negedge in an IDLE cycle (cycle 0) and returns at the negedge
    // of the IDLE cycle following DONE. For reads, data holds the beats memory returns.
    task automatic txn(input bit is_wr, input logic [31:0] addr, input line_t data,
                       input bit rand_resp, input logic [31:0] mask,
                       input int exp_done, input bit hold_after);
        int nb = 0;
        int stalls = 0;
        int done_cyc = 0;
        bit r;
        logic [31:0] aligned;
        aligned = addr & ~32'h1f;
        if (is_wr) begin
            write_i = 1'b1;
            line_i  = data;
        end else begin
            read_i = 1'b1;
        end
        address_i = addr;
        chk("idle_resp", resp_o, 0);
        for (int c = 1; c < 32 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (c == 1 && !hold_after) begin
                if (is_wr) write_i = 1'b0;
                else       read_i  = 1'b0;
            end
            address_i = $urandom;
            line_i    = rand_line();
            chk("read_o", read_o, !is_wr);
            chk("write_o", write_o, is_wr);
            chk("resp_busy", resp_o, 0);
            chk("address_o", address_o, aligned);
            if (is_wr) chk("burst_o", burst_o, data[64*nb +: 64]);
            else       chk("line_hold", line_o, last_fill);
            r = rand_resp ? (($urandom_range(0, 2) != 0) || stalls >= 3) : mask[c];
            resp_i  = r;
            burst_i = r ? data[64*nb +: 64] : {$urandom, $urandom};
            if (r) nb++;
            else   stalls++;
            if (nb == 4) done_cyc = c + 1;
        end
        if (done_cyc == 0) begin
            chk("burst_timeout", 1, 0);
            return;
        end
        if (exp_done != 0) chk("done_cycle", done_cyc, exp_done);
        @(negedge clk);
        resp_i  = $urandom;
        burst_i = {$urandom, $urandom};
        if (!is_wr) last_fill = data;
        last_addr = aligned;
        chk("resp_done", resp_o, 1);
        chk("read_o_done", read_o, 0);
        chk("write_o_done", write_o, 0);
        chk("line_o_done", line_o, last_fill);
        chk("address_done", address_o, last_addr);
        @(negedge clk);
        chk("resp_after", resp_o, 0);
        chk("read_o_after", read_o, 0);
        chk("write_o_after", write_o, 0);
        resp_i = 1'b0;
        if (!hold_after) begin
            if (is_wr) write_i = 1'b0;
            else       read_i  = 1'b0;
        end
    endtask

    initial begin
        line_t l;
        rst = 1'b1;
        line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        @(negedge clk);
        chk("rst_resp", resp_o, 0);
        chk("rst_read", read_o, 0);
        chk("rst_write", write_o, 0);
        chk("rst_addr", address_o, 0);
        chk("rst_burst", burst_o, 0);
        chk("rst_line", line_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // directed read with resp_i held high
        l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        txn(1'b0, 32'h0000_1234, l, 1'b0, 32'hFFFF_FFFE, 5, 1'b0);
        chk("dir_addr", address_o, 32'h0000_1220);
        chk("dir_line", line_o, l);

        // directed write with resp_i on cycles 2, 4, 5, 7
        l = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        txn(1'b1, 32'h8000_0040, l, 1'b0, 32'h0000_00B4, 8, 1'b0);

        // simultaneous read and write: write first, held read afterwards
        read_i = 1'b1;
        txn(1'b1, $urandom, rand_line(), 1'b1, 32'h0, 0, 1'b0);
        txn(1'b0, $urandom, rand_line(), 1'b1, 32'h0, 0, 1'b0);

        // reset after two beats of a read
        read_i = 1'b1; address_i = 32'h0000_5000;
        @(negedge clk);
        read_i = 1'b0; resp_i = 1'b1; burst_i = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        burst_i = 64'hFEDC_BA98_7654_3210;
        @(negedge clk);
        resp_i = 1'b0;
        chk("pre_rst_read", read_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_read", read_o, 0);
        chk("mid_rst_line", line_o, 0);
        chk("mid_rst_resp", resp_o, 0);
        last_fill = '0;
        last_addr = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_resp", resp_o, 0);
            chk("post_rst_read", read_o, 0);
        end
        txn(1'b0, $urandom, rand_line(), 1'b1, 32'h0, 0, 1'b0);

        // resp_i pulses while idle are ignored
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            resp_i = 1'b1; burst_i = {$urandom, $urandom}; address_i = $urandom;
            chk("idle_read", read_o | write_o | resp_o, 0);
            chk("idle_addr", address_o, last_addr);
            chk("idle_line", line_o, last_fill);
        end
        @(negedge clk);
        resp_i = 1'b0;
        txn(1'b0, $urandom, rand_line(), 1'b1, 32'h0, 0, 1'b0);

        // back-to-back reads with the request held through resp_o
        txn(1'b0, $urandom, rand_line(), 1'b0, 32'hFFFF_FFFE, 5, 1'b1);
        txn(1'b0, $urandom, rand_line(), 1'b1, 32'h0, 0, 1'b0);

        // random mix
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            txn(1'($urandom_range(0, 1)), $urandom, rand_line(), 1'b1, 32'h0, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
